// File: rtl/packet_injector.sv
// Source-side mesh network interface: splits a packet request into head/body/tail
// flits and injects them into the router's local port under credit flow control.
`ifndef X_NODES
`define X_NODES 4
`endif
`ifndef Y_NODES
`define Y_NODES 4
`endif

module packet_injector #(
    parameter int X_LOC   = 0,
    parameter int Y_LOC   = 0,
    parameter int DATA_W  = 16,
    parameter int PKT_LEN = 4,
    parameter int CREDITS = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_req_val,
    output logic                            o_req_rdy,
    input  logic [$clog2(`X_NODES)-1:0]     i_req_x_dest,
    input  logic [$clog2(`Y_NODES)-1:0]     i_req_y_dest,
    input  logic [DATA_W*(PKT_LEN-1)-1:0]   i_req_data,
    output logic                            o_req_err,
    output logic                            o_flit_val,
    output logic [1:0]                      o_flit_type,
    output logic [$clog2(`X_NODES)-1:0]     o_flit_x_dest,
    output logic [$clog2(`Y_NODES)-1:0]     o_flit_y_dest,
    output logic [DATA_W-1:0]               o_flit_data,
    input  logic                            i_credit
);

    localparam int XW = $clog2(`X_NODES);
    localparam int YW = $clog2(`Y_NODES);
    localparam int PW = DATA_W * (PKT_LEN - 1);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int IW = $clog2(PKT_LEN);

    localparam logic [1:0]    TYPE_HEAD = 2'b01;
    localparam logic [1:0]    TYPE_BODY = 2'b00;
    localparam logic [1:0]    TYPE_TAIL = 2'b10;
    localparam logic [IW-1:0] LAST_IDX  = IW'(PKT_LEN - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(CREDITS);

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [PW-1:0] data;
    } req_t;

    state_t        state, state_d;
    logic [IW-1:0] idx, idx_d;
    logic [CW-1:0] cnt, cnt_d;
    req_t          pkt;
    logic          hs, self_addr, latch, err_d, send, cr_inc;

    // Flit payload by index: slot 0 is the head (no payload), slot k is word k-1.
    logic [PKT_LEN-1:0][DATA_W-1:0] words;

    assign words[0] = '0;
    for (genvar k = 1; k < PKT_LEN; k++) begin : g_words
        assign words[k] = pkt.data[(k-1)*DATA_W +: DATA_W];
    end

    assign o_req_rdy = (state == IDLE) && !i_reset;
    assign hs        = i_req_val && o_req_rdy;
    assign self_addr = (i_req_x_dest == XW'(X_LOC)) && (i_req_y_dest == YW'(Y_LOC));

    always_comb begin
        state_d = state;
        idx_d   = idx;
        latch   = 1'b0;
        err_d   = 1'b0;
        send    = 1'b0;
        case (state)
            IDLE: begin
                if (hs) begin
                    if (self_addr) begin
                        err_d = 1'b1;
                    end else begin
                        latch   = 1'b1;
                        idx_d   = '0;
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (cnt != '0) begin
                    send = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A return at full count is dropped unless a flit leaves in the same cycle.
    assign cr_inc = i_credit && ((cnt != FULL_CNT) || send);
    assign cnt_d  = cnt + CW'(cr_inc) - CW'(send);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            idx           <= '0;
            cnt           <= FULL_CNT;
            pkt           <= '0;
            o_req_err     <= 1'b0;
            o_flit_val    <= 1'b0;
            o_flit_type   <= '0;
            o_flit_x_dest <= '0;
            o_flit_y_dest <= '0;
            o_flit_data   <= '0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            cnt        <= cnt_d;
            o_req_err  <= err_d;
            o_flit_val <= send;
            if (latch) begin
                pkt.x    <= i_req_x_dest;
                pkt.y    <= i_req_y_dest;
                pkt.data <= i_req_data;
            end
            if (send) begin
                o_flit_type   <= (idx == '0)       ? TYPE_HEAD :
                                 (idx == LAST_IDX) ? TYPE_TAIL : TYPE_BODY;
                o_flit_x_dest <= pkt.x;
                o_flit_y_dest <= pkt.y;
                o_flit_data   <= words[idx];
            end else begin
                o_flit_type   <= '0;
                o_flit_x_dest <= '0;
                o_flit_y_dest <= '0;
                o_flit_data   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_packet_injector.sv
// Directed bench for packet_injector: cycle table for the main flow plus
// hand-written reset and back-to-back sequences.
`ifndef X_NODES
`define X_NODES 4
`endif
`ifndef Y_NODES
`define Y_NODES 4
`endif

module tb_packet_injector;

    localparam logic [1:0] HD = 2'b01;
    localparam logic [1:0] BD = 2'b00;
    localparam logic [1:0] TL = 2'b10;

    logic        clk, rst;
    logic        req_val, req_rdy, req_err, credit;
    logic [1:0]  req_x, req_y;
    logic [47:0] req_data;
    logic        flit_val;
    logic [1:0]  flit_type, flit_x, flit_y;
    logic [15:0] flit_data;

    int n_chk  = 0;
    int n_fail = 0;

    packet_injector #(
        .X_LOC(1), .Y_LOC(1), .DATA_W(16), .PKT_LEN(4), .CREDITS(4)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req_val(req_val), .o_req_rdy(req_rdy),
        .i_req_x_dest(req_x), .i_req_y_dest(req_y), .i_req_data(req_data),
        .o_req_err(req_err),
        .o_flit_val(flit_val), .o_flit_type(flit_type),
        .o_flit_x_dest(flit_x), .o_flit_y_dest(flit_y), .o_flit_data(flit_data),
        .i_credit(credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  x, y;
        logic [47:0] d;
        logic        cr;
        logic        e_rdy, e_err, e_val;
        logic [1:0]  e_type, e_x, e_y;
        logic [15:0] e_data;
    } vec_t;

    localparam int NV = 33;
    vec_t vecs[NV];

    function automatic vec_t mk(logic v, logic [1:0] x, logic [1:0] y, logic [47:0] d,
                                logic cr, logic rdy, logic err, logic fv,
                                logic [1:0] ft, logic [1:0] fx, logic [1:0] fy,
                                logic [15:0] fd);
        vec_t r;
        r.v = v; r.x = x; r.y = y; r.d = d; r.cr = cr;
        r.e_rdy = rdy; r.e_err = err; r.e_val = fv;
        r.e_type = ft; r.e_x = fx; r.e_y = fy; r.e_data = fd;
        return r;
    endfunction

    task automatic chk(input string name, input int tag, input logic [47:0] act,
                       input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h expected %h", name, tag, act, exp);
        end
    endtask

    task automatic chk_out(input int tag, input logic rdy, input logic err,
                           input logic fv, input logic [1:0] ft, input logic [1:0] fx,
                           input logic [1:0] fy, input logic [15:0] fd);
        chk("req_rdy",   tag, 48'(req_rdy),   48'(rdy));
        chk("req_err",   tag, 48'(req_err),   48'(err));
        chk("flit_val",  tag, 48'(flit_val),  48'(fv));
        chk("flit_type", tag, 48'(flit_type), 48'(ft));
        chk("flit_x",    tag, 48'(flit_x),    48'(fx));
        chk("flit_y",    tag, 48'(flit_y),    48'(fy));
        chk("flit_data", tag, 48'(flit_data), 48'(fd));
    endtask

    localparam logic [47:0] D1 = {16'h4444, 16'h3333, 16'h2222};
    localparam logic [47:0] D2 = {16'h7777, 16'h6666, 16'h5555};
    localparam logic [47:0] D3 = {16'h0003, 16'h0002, 16'h0001};
    localparam logic [47:0] D4 = {16'hcccc, 16'hbbbb, 16'haaaa};

    initial begin
        // Rows: outputs expected in the cycle, inputs driven in that cycle.
        vecs[0]  = mk(1, 3, 2, D1, 0,  1, 0, 0, BD, 0, 0, 16'h0);
        vecs[1]  = mk(0, 0, 0, 0,  0,  0, 0, 0, BD, 0, 0, 16'h0);
        vecs[2]  = mk(0, 0, 0, 0,  0,  0, 0, 1, HD, 3, 2, 16'h0);
        vecs[3]  = mk(0, 0, 0, 0,  0,  0, 0, 1, BD, 3, 2, 16'h2222);
        vecs[4]  = mk(0, 0, 0, 0,  0,  0, 0, 1, BD, 3, 2, 16'h3333);
        vecs[5]  = mk(0, 0, 0, 0,  0,  1, 0, 1, TL, 3, 2, 16'h4444);
        vecs[6]  = mk(1, 1, 1, D1, 0,  1, 0, 0, BD, 0, 0, 16'h0);
        vecs[7]  = mk(0, 0, 0, 0,  0,  1, 1, 0, BD, 0, 0, 16'h0);
        vecs[8]  = mk(1, 2, 3, D2, 0,  1, 0, 0, BD, 0, 0, 16'h0);
        vecs[9]  = mk(0, 0, 0, 0,  0,  0, 0, 0, BD, 0, 0, 16'h0);
        vecs[10] = mk(0, 0, 0, 0,  0,  0, 0, 0, BD, 0, 0, 16'h0);
        vecs[11] = mk(0, 0, 0, 0,  1,  0, 0, 0, BD, 0, 0, 16'h0);
        vecs[12] = mk(0, 0, 0, 0,  0,  0, 0, 0, BD, 0, 0, 16'h0);
        vecs[13] = mk(0, 0, 0, 0,  0,  0, 0, 1, HD, 2, 3, 16'h0);
        vecs[14] = mk(0, 0, 0, 0,  0,  0, 0, 0, BD, 0, 0, 16'h0);
        vecs[15] = mk(0, 0, 0, 0,  1,  0, 0, 0, BD, 0, 0, 16'h0);
        vecs[16] = mk(0, 0, 0, 0,  1,  0, 0, 0, BD, 0, 0, 16'h0);
        vecs[17] = mk(0, 0, 0, 0,  1,  0, 0, 1, BD, 2, 3, 16'h5555);
        vecs[18] = mk(0, 0, 0, 0,  1,  0, 0, 1, BD, 2, 3, 16'h6666);
        vecs[19] = mk(0, 0, 0, 0,  1,  1, 0, 1, TL, 2, 3, 16'h7777);
        vecs[20] = mk(0, 0, 0, 0,  1,  1, 0, 0, BD, 0, 0, 16'h0);
        vecs[21] = mk(0, 0, 0, 0,  1,  1, 0, 0, BD, 0, 0, 16'h0);
        vecs[22] = mk(0, 0, 0, 0,  1,  1, 0, 0, BD, 0, 0, 16'h0);
        vecs[23] = mk(0, 0, 0, 0,  1,  1, 0, 0, BD, 0, 0, 16'h0);
        vecs[24] = mk(1, 3, 0, D3, 0,  1, 0, 0, BD, 0, 0, 16'h0);
        vecs[25] = mk(1, 0, 3, D1, 0,  0, 0, 0, BD, 0, 0, 16'h0);
        vecs[26] = mk(1, 0, 3, D1, 0,  0, 0, 1, HD, 3, 0, 16'h0);
        vecs[27] = mk(1, 0, 3, D1, 0,  0, 0, 1, BD, 3, 0, 16'h0001);
        vecs[28] = mk(1, 0, 3, D1, 0,  0, 0, 1, BD, 3, 0, 16'h0002);
        vecs[29] = mk(1, 3, 0, D3, 0,  1, 0, 1, TL, 3, 0, 16'h0003);
        vecs[30] = mk(1, 3, 0, D3, 0,  0, 0, 0, BD, 0, 0, 16'h0);
        vecs[31] = mk(1, 3, 0, D3, 0,  0, 0, 0, BD, 0, 0, 16'h0);
        vecs[32] = mk(0, 0, 0, 0,  0,  0, 0, 0, BD, 0, 0, 16'h0);

        rst = 1'b1; req_val = 1'b0; req_x = '0; req_y = '0; req_data = '0; credit = 1'b0;
        #2;
        chk_out(-1, 0, 0, 0, BD, 0, 0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < NV; r++) begin
            @(negedge clk);
            chk_out(r, vecs[r].e_rdy, vecs[r].e_err, vecs[r].e_val, vecs[r].e_type,
                    vecs[r].e_x, vecs[r].e_y, vecs[r].e_data);
            req_val = vecs[r].v; req_x = vecs[r].x; req_y = vecs[r].y;
            req_data = vecs[r].d; credit = vecs[r].cr;
        end

        // Reset mid-packet: outputs clear at once, no tail, credits refilled.
        rst = 1'b1;
        #1 chk_out(100, 0, 0, 0, BD, 0, 0, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        req_val = 1'b1; req_x = 2'd3; req_y = 2'd2; req_data = D1;
        @(negedge clk);
        chk_out(101, 0, 0, 0, BD, 0, 0, 16'h0);
        req_val = 1'b0;
        @(negedge clk);
        chk_out(102, 0, 0, 1, HD, 3, 2, 16'h0);
        @(negedge clk);
        chk_out(103, 0, 0, 1, BD, 3, 2, 16'h2222);
        rst = 1'b1;
        #1 chk_out(104, 0, 0, 0, BD, 0, 0, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_out(105 + i, 1, 0, 0, BD, 0, 0, 16'h0);
        end
        req_val = 1'b1; req_x = 2'd2; req_y = 2'd0; req_data = D4;
        @(negedge clk);
        chk_out(110, 0, 0, 0, BD, 0, 0, 16'h0);
        req_val = 1'b0;
        @(negedge clk);
        chk_out(111, 0, 0, 1, HD, 2, 0, 16'h0);
        @(negedge clk);
        chk_out(112, 0, 0, 1, BD, 2, 0, 16'haaaa);
        @(negedge clk);
        chk_out(113, 0, 0, 1, BD, 2, 0, 16'hbbbb);
        @(negedge clk);
        chk_out(114, 1, 0, 1, TL, 2, 0, 16'hcccc);

        // Request held high with steady credit returns: 4 flits, 1 idle cycle.
        req_val = 1'b1; req_x = 2'd1; req_y = 2'd3; req_data = D3; credit = 1'b1;
        for (int i = 0; i < 11; i++) begin
            int p;
            logic [1:0]  et;
            logic [15:0] ed;
            p  = i % 5;
            et = (p == 1) ? HD : (p == 4) ? TL : BD;
            ed = (p == 0 || p == 1) ? 16'h0 : 16'(p - 1);
            @(negedge clk);
            chk_out(120 + i, (p == 4), 0, (p != 0), et,
                    (p != 0) ? 2'd1 : 2'd0, (p != 0) ? 2'd3 : 2'd0, ed);
        end
        req_val = 1'b0; credit = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
